// File: rtl/transpose_buffer.sv
// Ping-pong 8x8 transpose memory: row-major samples in, column-major samples out.
// Two banks alternate so one block fills while the other drains without bubbles.
module transpose_buffer #(
    parameter int W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_first,
    output logic                out_last
);

    logic signed [W-1:0] bank_q [2][64];

    logic [1:0] full_q, full_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    logic [5:0] wc_q, wc_d;
    logic [5:0] rc_q, rc_d;

    logic       wr_fire;
    logic       rd_fire;
    logic [5:0] rd_addr;

    // Sample k of the output is row k[2:0], column k[5:3] of the stored block.
    assign rd_addr   = {rc_q[2:0], rc_q[5:3]};
    assign in_ready  = ~full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;
    assign out_data  = out_valid ? bank_q[rb_q][rd_addr] : '0;
    assign out_first = out_valid & (rc_q == 6'd0);
    assign out_last  = out_valid & (rc_q == 6'd63);

    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        wc_d   = wc_q;
        rb_d   = rb_q;
        rc_d   = rc_q;
        if (wr_fire) begin
            wc_d = wc_q + 6'd1;
            if (wc_q == 6'd63) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end
        // Write and read always target different banks, so both flag updates can coexist.
        if (rd_fire) begin
            rc_d = rc_q + 6'd1;
            if (rc_q == 6'd63) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wc_q   <= 6'd0;
            rc_q   <= 6'd0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wc_q   <= wc_d;
            rc_q   <= rc_d;
        end
    end

    // Sample storage carries no reset; the full flags alone qualify its contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_q[wb_q][wc_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_transpose_buffer.sv
// Directed and random bench for transpose_buffer with a transposing scoreboard.
module tb_transpose_buffer;

    localparam int W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic                out_first;
    logic                out_last;

    logic rdy_dir;
    logic rand_rdy;
    logic rnd_bit;

    int n_assert = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int n_stall  = 0;
    int wcnt     = 0;
    int rd_k     = 0;

    logic signed [W-1:0] blk [64];
    logic signed [W-1:0] expq [$];

    assign out_ready = rand_rdy ? rnd_bit : rdy_dir;

    always #5 clk = ~clk;

    transpose_buffer #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_first(out_first),
        .out_last (out_last)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(1));
    end

    // Scoreboard: a completed input block pushes its transpose; outputs are compared against the head.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            wcnt = 0;
            rd_k = 0;
        end else begin
            if (out_valid) begin
                check("out_has_expect", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    check("out_data", out_data, expq[0]);
                    check("out_first", out_first, rd_k == 0);
                    check("out_last", out_last, rd_k == 63);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        rd_k = (rd_k + 1) % 64;
                        n_out++;
                    end
                end
            end else begin
                check("idle_data", out_data, 0);
            end
            if (in_valid && in_ready) begin
                blk[wcnt] = in_data;
                wcnt++;
                n_acc++;
                if (wcnt == 64) begin
                    for (int k = 0; k < 64; k++) expq.push_back(blk[(k % 8) * 8 + k / 8]);
                    wcnt = 0;
                end
            end
        end
    end

    task automatic send(input logic signed [W-1:0] v);
        int t;
        in_data  = v;
        in_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
            n_stall++;
        end
        if (t == 200) check("send_timeout", t, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (expq.size() == 0) break;
        end
        check("drain_timeout", expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; rdy_dir = 1'b0; rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        // T1 single block
        rdy_dir = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) check("t1_not_early", out_valid, 0);
            send(W'(i));
        end
        in_valid = 1'b0;
        check("t1_valid_rise", out_valid, 1);
        check("t1_first_val", out_data, 0);
        check("t1_first_flag", out_first, 1);
        drain();
        check("t1_count", n_out, 64);
        check("t1_idle", out_valid, 0);

        // T2 streaming
        st = n_stall;
        for (int i = 0; i < 192; i++) begin
            send(W'(i * 21 - 2000));
            if (i >= 63) check("t2_cont_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        check("t2_no_stall", n_stall - st, 0);
        drain();

        // T3 backpressure
        rdy_dir = 1'b0;
        st = n_acc;
        for (int i = 0; i < 128; i++) send(W'(-i));
        check("t3_full", in_ready, 0);
        in_data = W'(999);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_accepted", n_acc - st, 128);
        check("t3_still_full", in_ready, 0);
        rdy_dir = 1'b1;
        @(posedge clk); #1 rdy_dir = 1'b0;
        check("t3_one_read", in_ready, 0);
        rdy_dir = 1'b1;
        repeat (62) @(posedge clk);
        #1;
        check("t3_63_reads", in_ready, 0);
        check("t3_last_flag", out_last, 1);
        @(posedge clk); #1;
        check("t3_freed", in_ready, 1);
        check("t3_b1_valid", out_valid, 1);
        drain();

        // T4 random stalls
        rand_rdy = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 64; i++) begin
                while ($urandom_range(2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                if (i == 5) send(W'(-2048));
                else if (i == 58) send(W'(2047));
                else send(W'($urandom));
            end
        end
        in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;

        // T5 reset mid-drain
        rdy_dir = 1'b0;
        for (int i = 0; i < 96; i++) send(W'(i + 500));
        in_valid = 1'b0;
        rdy_dir = 1'b1;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_valid_low", out_valid, 0);
        check("t5_ready_high", in_ready, 1);
        check("t5_data_zero", out_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        check("t5_post_idle", out_valid, 0);
        st = n_out;
        for (int i = 0; i < 64; i++) send(W'(100 + i));
        in_valid = 1'b0;
        check("t5_first_val", out_data, 100);
        drain();
        check("t5_count", n_out - st, 64);

        // T6 signed passthrough
        for (int i = 0; i < 64; i++) send((i % 2 == 1) ? W'(-2048) : W'(-1));
        in_valid = 1'b0;
        check("t6_first_val", out_data, -1);
        @(posedge clk); #1;
        check("t6_second_val", out_data, -1);
        drain();
        check("final_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
